// File: rtl/decode_issue_stage.sv
// Two-lane decode/issue stage: dual control decode, 4R/2W register file with write-back
// bypass, registered ID/EX boundary, and splitting of intra-bundle conflicting pairs.

module controlUnit (
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output logic [14:0] ctrl
);
   logic       reg_dst, branch, mem_read, mem_to_reg, mem_write, reg_write, alu_src;
   logic       jr, jal, bne, jump;
   logic [3:0] alu_op;

   // Opcode/funct decode into the packed control vector
   always_comb begin
      reg_dst = 1'b0; branch = 1'b0; mem_read = 1'b0; mem_to_reg = 1'b0;
      mem_write = 1'b0; reg_write = 1'b0; alu_src = 1'b0; jr = 1'b0;
      jal = 1'b0; bne = 1'b0; jump = 1'b0; alu_op = 4'd0;
      case (opcode)
         6'h00: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            case (funct)
               6'h20:   alu_op = 4'd0;
               6'h22:   alu_op = 4'd1;
               6'h24:   alu_op = 4'd2;
               6'h25:   alu_op = 4'd3;
               6'h26:   alu_op = 4'd4;
               6'h27:   alu_op = 4'd5;
               6'h2a:   alu_op = 4'd6;
               6'h00:   alu_op = 4'd7;
               6'h02:   alu_op = 4'd8;
               6'h08:   begin reg_dst = 1'b0; reg_write = 1'b0; jr = 1'b1; end
               default: begin reg_dst = 1'b0; reg_write = 1'b0; end
            endcase
         end
         6'h08:   begin reg_write = 1'b1; alu_src = 1'b1; end
         6'h0c:   begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 4'd2; end
         6'h0d:   begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 4'd3; end
         6'h0e:   begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 4'd4; end
         6'h0a:   begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 4'd6; end
         6'h23:   begin mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; alu_src = 1'b1; end
         6'h2b:   begin mem_write = 1'b1; alu_src = 1'b1; end
         6'h04:   begin branch = 1'b1; alu_op = 4'd1; end
         6'h05:   begin bne = 1'b1; alu_op = 4'd1; end
         6'h02:   jump = 1'b1;
         6'h03:   begin jal = 1'b1; jump = 1'b1; reg_write = 1'b1; end
         default: alu_op = 4'd0;
      endcase
      ctrl = {reg_dst, branch, mem_read, mem_to_reg, mem_write, reg_write, alu_src,
              jr, jal, bne, jump, alu_op};
   end
endmodule

module decode_issue_stage #(
   parameter int DATA_W   = 32,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction1,
   input  logic [31:0]       instruction2,
   input  logic              stall,
   input  logic              flush,
   input  logic              regWrite1_WB,
   input  logic              regWrite2_WB,
   input  logic              jal1_WB,
   input  logic              jal2_WB,
   input  logic [4:0]        writeReg1_WB,
   input  logic [4:0]        writeReg2_WB,
   input  logic [DATA_W-1:0] writeData1_WB,
   input  logic [DATA_W-1:0] writeData2_WB,
   output logic              out_valid1,
   output logic              out_valid2,
   output logic [14:0]       ctrl1,
   output logic [14:0]       ctrl2,
   output logic [4:0]        rs1,
   output logic [4:0]        rt1,
   output logic [4:0]        destReg1,
   output logic [4:0]        shamt1,
   output logic [4:0]        rs2,
   output logic [4:0]        rt2,
   output logic [4:0]        destReg2,
   output logic [4:0]        shamt2,
   output logic [DATA_W-1:0] readData1_1,
   output logic [DATA_W-1:0] readData2_1,
   output logic [DATA_W-1:0] readData1_2,
   output logic [DATA_W-1:0] readData2_2,
   output logic [DATA_W-1:0] extImm1,
   output logic [DATA_W-1:0] extImm2
);
   typedef enum logic {PAIR = 1'b0, HOLD = 1'b1} state_t;

   typedef struct packed {
      logic [14:0]       ctrl;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        dest;
      logic [4:0]        shamt;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
   } lane_t;

   localparam int CB_REGDST = 14;
   localparam int CB_BRANCH = 13;
   localparam int CB_MEMRD  = 12;
   localparam int CB_MEMWR  = 10;
   localparam int CB_REGWR  = 9;
   localparam int CB_JR     = 7;
   localparam int CB_JAL    = 6;
   localparam int CB_BNE    = 5;
   localparam int CB_JUMP   = 4;
   localparam logic [4:0] LINK_REG = 5'd31;

   // Port 2 is checked first so it wins when both ports target the same register
   function automatic logic [DATA_W-1:0] bypass_read(
      input logic [4:0] ra, input logic [DATA_W-1:0] arr_val,
      input logic we1, input logic [4:0] wa1, input logic [DATA_W-1:0] wd1,
      input logic we2, input logic [4:0] wa2, input logic [DATA_W-1:0] wd2);
      logic [DATA_W-1:0] v;
      if (ra == 5'd0)                 v = {DATA_W{1'b0}};
      else if (we2 && (wa2 == ra))    v = wd2;
      else if (we1 && (wa1 == ra))    v = wd1;
      else                            v = arr_val;
      return v;
   endfunction

   state_t            state_q, state_d;
   logic [31:0]       hold_q, hold_d;
   logic              valid1_q, valid1_d, valid2_q, valid2_d;
   lane_t             lane1_q, lane1_d, lane2_q, lane2_d;
   lane_t             lane_a_s, lane_b_s;
   logic [DATA_W-1:0] rf_q [32];
   logic [DATA_W-1:0] rf_d [32];
   logic [31:0]       lane1_ins_s;
   logic [14:0]       ctrl_a_s, ctrl_b_s;
   logic [4:0]        wa1_s, wa2_s, eff_dest_a_s, eff_dest_b_s;
   logic              conflict_s;

   assign wa1_s       = jal1_WB ? LINK_REG : writeReg1_WB;
   assign wa2_s       = jal2_WB ? LINK_REG : writeReg2_WB;
   assign lane1_ins_s = (state_q == HOLD) ? hold_q : instruction1;
   assign in_ready    = (state_q == PAIR) && !stall;

   controlUnit u_cu1 (.opcode(lane1_ins_s[31:26]), .funct(lane1_ins_s[5:0]), .ctrl(ctrl_a_s));
   controlUnit u_cu2 (.opcode(instruction2[31:26]), .funct(instruction2[5:0]), .ctrl(ctrl_b_s));

   // Field extraction and operand read for both lanes
   always_comb begin
      lane_a_s.ctrl  = ctrl_a_s;
      lane_a_s.rs    = lane1_ins_s[25:21];
      lane_a_s.rt    = lane1_ins_s[20:16];
      lane_a_s.dest  = ctrl_a_s[CB_REGDST] ? lane1_ins_s[15:11] : lane1_ins_s[20:16];
      lane_a_s.shamt = lane1_ins_s[10:6];
      lane_a_s.rd1   = bypass_read(lane1_ins_s[25:21], rf_q[lane1_ins_s[25:21]], regWrite1_WB,
                                   wa1_s, writeData1_WB, regWrite2_WB, wa2_s, writeData2_WB);
      lane_a_s.rd2   = bypass_read(lane1_ins_s[20:16], rf_q[lane1_ins_s[20:16]], regWrite1_WB,
                                   wa1_s, writeData1_WB, regWrite2_WB, wa2_s, writeData2_WB);
      lane_a_s.imm   = {{(DATA_W-16){lane1_ins_s[15]}}, lane1_ins_s[15:0]};
      lane_b_s.ctrl  = ctrl_b_s;
      lane_b_s.rs    = instruction2[25:21];
      lane_b_s.rt    = instruction2[20:16];
      lane_b_s.dest  = ctrl_b_s[CB_REGDST] ? instruction2[15:11] : instruction2[20:16];
      lane_b_s.shamt = instruction2[10:6];
      lane_b_s.rd1   = bypass_read(instruction2[25:21], rf_q[instruction2[25:21]], regWrite1_WB,
                                   wa1_s, writeData1_WB, regWrite2_WB, wa2_s, writeData2_WB);
      lane_b_s.rd2   = bypass_read(instruction2[20:16], rf_q[instruction2[20:16]], regWrite1_WB,
                                   wa1_s, writeData1_WB, regWrite2_WB, wa2_s, writeData2_WB);
      lane_b_s.imm   = {{(DATA_W-16){instruction2[15]}}, instruction2[15:0]};
   end

   // A jal writes the link register regardless of its encoded dest field
   assign eff_dest_a_s = ctrl_a_s[CB_JAL] ? LINK_REG : lane_a_s.dest;
   assign eff_dest_b_s = ctrl_b_s[CB_JAL] ? LINK_REG : lane_b_s.dest;
   assign conflict_s = SPLIT_EN && (
        (ctrl_a_s[CB_REGWR] && (eff_dest_a_s != 5'd0) &&
         ((eff_dest_a_s == lane_b_s.rs) || (eff_dest_a_s == lane_b_s.rt)))
     || (ctrl_a_s[CB_REGWR] && ctrl_b_s[CB_REGWR] && (eff_dest_a_s == eff_dest_b_s))
     || ((ctrl_a_s[CB_MEMRD] || ctrl_a_s[CB_MEMWR]) && (ctrl_b_s[CB_MEMRD] || ctrl_b_s[CB_MEMWR]))
     || ctrl_a_s[CB_BRANCH] || ctrl_a_s[CB_BNE] || ctrl_a_s[CB_JUMP]
     || ctrl_a_s[CB_JR] || ctrl_a_s[CB_JAL]);

   // Issue control: flush beats stall, HOLD drains the held lane-2 instruction
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      valid1_d = valid1_q;
      valid2_d = valid2_q;
      lane1_d  = lane1_q;
      lane2_d  = lane2_q;
      if (flush) begin
         valid1_d     = 1'b0;
         valid2_d     = 1'b0;
         lane1_d.ctrl = 15'd0;
         lane2_d.ctrl = 15'd0;
         hold_d       = 32'd0;
         state_d      = PAIR;
      end else if (stall) begin
         state_d = state_q;
      end else if (state_q == HOLD) begin
         lane1_d  = lane_a_s;
         valid1_d = 1'b1;
         valid2_d = 1'b0;
         hold_d   = 32'd0;
         state_d  = PAIR;
      end else if (in_valid) begin
         lane1_d  = lane_a_s;
         valid1_d = 1'b1;
         if (conflict_s) begin
            valid2_d = 1'b0;
            hold_d   = instruction2;
            state_d  = HOLD;
         end else begin
            lane2_d  = lane_b_s;
            valid2_d = 1'b1;
         end
      end else begin
         valid1_d = 1'b0;
         valid2_d = 1'b0;
      end
   end

   // Register-file write; entry 0 is never written
   always_comb begin
      rf_d = rf_q;
      if (regWrite1_WB && (wa1_s != 5'd0)) rf_d[wa1_s] = writeData1_WB;
      else                                 rf_d[0]     = rf_q[0];
      if (regWrite2_WB && (wa2_s != 5'd0)) rf_d[wa2_s] = writeData2_WB;
      else                                 rf_d[0]     = rf_q[0];
   end

   // Stage state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= PAIR;
         hold_q   <= 32'd0;
         valid1_q <= 1'b0;
         valid2_q <= 1'b0;
         lane1_q  <= '0;
         lane2_q  <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         valid1_q <= valid1_d;
         valid2_q <= valid2_d;
         lane1_q  <= lane1_d;
         lane2_q  <= lane2_d;
      end
   end

   // Register-file storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= {DATA_W{1'b0}};
      end else begin
         rf_q <= rf_d;
      end
   end

   assign out_valid1  = valid1_q;
   assign out_valid2  = valid2_q;
   assign ctrl1       = lane1_q.ctrl;
   assign rs1         = lane1_q.rs;
   assign rt1         = lane1_q.rt;
   assign destReg1    = lane1_q.dest;
   assign shamt1      = lane1_q.shamt;
   assign readData1_1 = lane1_q.rd1;
   assign readData2_1 = lane1_q.rd2;
   assign extImm1     = lane1_q.imm;
   assign ctrl2       = lane2_q.ctrl;
   assign rs2         = lane2_q.rs;
   assign rt2         = lane2_q.rt;
   assign destReg2    = lane2_q.dest;
   assign shamt2      = lane2_q.shamt;
   assign readData1_2 = lane2_q.rd1;
   assign readData2_2 = lane2_q.rd2;
   assign extImm2     = lane2_q.imm;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized + directed bench for decode_issue_stage against a mnemonic-level reference model.

module tb_decode_issue_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [31:0] instruction1 = 32'd0, instruction2 = 32'd0;
   logic        regWrite1_WB = 1'b0, regWrite2_WB = 1'b0, jal1_WB = 1'b0, jal2_WB = 1'b0;
   logic [4:0]  writeReg1_WB = 5'd0, writeReg2_WB = 5'd0;
   logic [31:0] writeData1_WB = 32'd0, writeData2_WB = 32'd0;

   logic        in_ready, out_valid1, out_valid2;
   logic [14:0] ctrl1, ctrl2;
   logic [4:0]  rs1, rt1, destReg1, shamt1, rs2, rt2, destReg2, shamt2;
   logic [31:0] readData1_1, readData2_1, readData1_2, readData2_2, extImm1, extImm2;

   logic        in_ready_ns, out_valid1_ns, out_valid2_ns;
   logic [14:0] ctrl1_ns, ctrl2_ns;
   logic [4:0]  rs1_ns, rt1_ns, destReg1_ns, shamt1_ns, rs2_ns, rt2_ns, destReg2_ns, shamt2_ns;
   logic [31:0] rd11_ns, rd21_ns, rd12_ns, rd22_ns, imm1_ns, imm2_ns;

   decode_issue_stage #(.DATA_W(32), .SPLIT_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instruction1(instruction1), .instruction2(instruction2), .stall(stall), .flush(flush),
      .regWrite1_WB(regWrite1_WB), .regWrite2_WB(regWrite2_WB), .jal1_WB(jal1_WB), .jal2_WB(jal2_WB),
      .writeReg1_WB(writeReg1_WB), .writeReg2_WB(writeReg2_WB),
      .writeData1_WB(writeData1_WB), .writeData2_WB(writeData2_WB),
      .out_valid1(out_valid1), .out_valid2(out_valid2), .ctrl1(ctrl1), .ctrl2(ctrl2),
      .rs1(rs1), .rt1(rt1), .destReg1(destReg1), .shamt1(shamt1),
      .rs2(rs2), .rt2(rt2), .destReg2(destReg2), .shamt2(shamt2),
      .readData1_1(readData1_1), .readData2_1(readData2_1),
      .readData1_2(readData1_2), .readData2_2(readData2_2),
      .extImm1(extImm1), .extImm2(extImm2));

   decode_issue_stage #(.DATA_W(32), .SPLIT_EN(1'b0)) u_dut_ns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ns),
      .instruction1(instruction1), .instruction2(instruction2), .stall(stall), .flush(flush),
      .regWrite1_WB(regWrite1_WB), .regWrite2_WB(regWrite2_WB), .jal1_WB(jal1_WB), .jal2_WB(jal2_WB),
      .writeReg1_WB(writeReg1_WB), .writeReg2_WB(writeReg2_WB),
      .writeData1_WB(writeData1_WB), .writeData2_WB(writeData2_WB),
      .out_valid1(out_valid1_ns), .out_valid2(out_valid2_ns), .ctrl1(ctrl1_ns), .ctrl2(ctrl2_ns),
      .rs1(rs1_ns), .rt1(rt1_ns), .destReg1(destReg1_ns), .shamt1(shamt1_ns),
      .rs2(rs2_ns), .rt2(rt2_ns), .destReg2(destReg2_ns), .shamt2(shamt2_ns),
      .readData1_1(rd11_ns), .readData2_1(rd21_ns), .readData1_2(rd12_ns), .readData2_2(rd22_ns),
      .extImm1(imm1_ns), .extImm2(imm2_ns));

   typedef enum int {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLL, M_SRL, M_JR,
                     M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE,
                     M_J, M_JAL, M_UNK} mn_t;

   typedef struct packed {
      logic reg_dst, branch, mem_read, mem_to_reg, mem_write, reg_write, alu_src, jr, jal, bne, jump;
      logic [3:0] alu_op;
   } cv_t;

   typedef struct {
      cv_t c; logic [4:0] rs, rt, dest, sh; logic [31:0] a, b, imm;
   } lane_t;

   int n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(mn_t m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                       logic [4:0] sh, logic [15:0] imm);
      logic [5:0] op = 6'h00, fn = 6'h00;
      case (m)
         M_ADD: fn = 6'h20;  M_SUB: fn = 6'h22;  M_AND: fn = 6'h24;  M_OR:  fn = 6'h25;
         M_XOR: fn = 6'h26;  M_NOR: fn = 6'h27;  M_SLT: fn = 6'h2a;  M_SLL: fn = 6'h00;
         M_SRL: fn = 6'h02;  M_JR:  fn = 6'h08;
         M_ADDI: op = 6'h08; M_ANDI: op = 6'h0c; M_ORI: op = 6'h0d; M_XORI: op = 6'h0e;
         M_SLTI: op = 6'h0a; M_LW:   op = 6'h23; M_SW:  op = 6'h2b; M_BEQ:  op = 6'h04;
         M_BNE:  op = 6'h05; M_J:    op = 6'h02; M_JAL: op = 6'h03;
         default: op = 6'h3f;
      endcase
      if (op == 6'h00) return {op, rs, rt, rd, sh, fn};
      return {op, rs, rt, imm};
   endfunction

   function automatic mn_t mnem(logic [31:0] ins);
      if (ins[31:26] == 6'h00) begin
         case (ins[5:0])
            6'h20: return M_ADD; 6'h22: return M_SUB; 6'h24: return M_AND; 6'h25: return M_OR;
            6'h26: return M_XOR; 6'h27: return M_NOR; 6'h2a: return M_SLT; 6'h00: return M_SLL;
            6'h02: return M_SRL; 6'h08: return M_JR;  default: return M_UNK;
         endcase
      end
      case (ins[31:26])
         6'h08: return M_ADDI; 6'h0c: return M_ANDI; 6'h0d: return M_ORI; 6'h0e: return M_XORI;
         6'h0a: return M_SLTI; 6'h23: return M_LW;   6'h2b: return M_SW;  6'h04: return M_BEQ;
         6'h05: return M_BNE;  6'h02: return M_J;    6'h03: return M_JAL; default: return M_UNK;
      endcase
   endfunction

   function automatic cv_t ctrl_of(mn_t m);
      cv_t c = '0;
      c.reg_dst    = m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLL, M_SRL};
      c.reg_write  = c.reg_dst || (m inside {M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_LW, M_JAL});
      c.alu_src    = m inside {M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_LW, M_SW};
      c.branch     = (m == M_BEQ);
      c.mem_read   = (m == M_LW);
      c.mem_to_reg = (m == M_LW);
      c.mem_write  = (m == M_SW);
      c.jr         = (m == M_JR);
      c.jal        = (m == M_JAL);
      c.bne        = (m == M_BNE);
      c.jump       = m inside {M_J, M_JAL};
      case (m)
         M_SUB, M_BEQ, M_BNE: c.alu_op = 4'd1;
         M_AND, M_ANDI:       c.alu_op = 4'd2;
         M_OR, M_ORI:         c.alu_op = 4'd3;
         M_XOR, M_XORI:       c.alu_op = 4'd4;
         M_NOR:               c.alu_op = 4'd5;
         M_SLT, M_SLTI:       c.alu_op = 4'd6;
         M_SLL:               c.alu_op = 4'd7;
         M_SRL:               c.alu_op = 4'd8;
         default:             c.alu_op = 4'd0;
      endcase
      return c;
   endfunction

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_held [$];
   lane_t       e_l1, e_l2;
   bit          e_v1, e_v2, e_z1, e_z2;

   function automatic lane_t mk_lane(logic [31:0] ins);
      lane_t l;
      l.c    = ctrl_of(mnem(ins));
      l.rs   = ins[25:21];
      l.rt   = ins[20:16];
      l.dest = l.c.reg_dst ? ins[15:11] : ins[20:16];
      l.sh   = ins[10:6];
      l.a    = m_regs[l.rs];
      l.b    = m_regs[l.rt];
      l.imm  = {{16{ins[15]}}, ins[15:0]};
      return l;
   endfunction

   function automatic bit must_split(logic [31:0] i1, logic [31:0] i2);
      lane_t x = mk_lane(i1), y = mk_lane(i2);
      logic [4:0] d1 = x.c.jal ? 5'd31 : x.dest;
      logic [4:0] d2 = y.c.jal ? 5'd31 : y.dest;
      if (x.c.reg_write && d1 != 5'd0 && (d1 == y.rs || d1 == y.rt)) return 1'b1;
      if (x.c.reg_write && y.c.reg_write && d1 == d2) return 1'b1;
      if ((x.c.mem_read || x.c.mem_write) && (y.c.mem_read || y.c.mem_write)) return 1'b1;
      return x.c.branch || x.c.bne || x.c.jump || x.c.jr || x.c.jal;
   endfunction

   task automatic model_clock();
      logic [4:0] a;
      a = jal1_WB ? 5'd31 : writeReg1_WB;
      if (regWrite1_WB && a != 5'd0) m_regs[a] = writeData1_WB;
      a = jal2_WB ? 5'd31 : writeReg2_WB;
      if (regWrite2_WB && a != 5'd0) m_regs[a] = writeData2_WB;
      if (flush) begin
         e_v1 = 0; e_v2 = 0; e_z1 = 1; e_z2 = 1; m_held.delete();
      end else if (stall) begin
         e_v1 = e_v1;
      end else if (m_held.size() != 0) begin
         e_l1 = mk_lane(m_held.pop_front()); e_v1 = 1; e_v2 = 0; e_z1 = 0;
      end else if (in_valid) begin
         e_l1 = mk_lane(instruction1); e_v1 = 1; e_z1 = 0;
         if (must_split(instruction1, instruction2)) begin
            e_v2 = 0; m_held.push_back(instruction2);
         end else begin
            e_l2 = mk_lane(instruction2); e_v2 = 1; e_z2 = 0;
         end
      end else begin
         e_v1 = 0; e_v2 = 0;
      end
   endtask

   task automatic compare();
      check("out_valid1", out_valid1, e_v1);
      check("out_valid2", out_valid2, e_v2);
      if (e_v1) begin
         check("ctrl1", ctrl1, e_l1.c);
         check("l1_fields", {rs1, rt1, destReg1, shamt1}, {e_l1.rs, e_l1.rt, e_l1.dest, e_l1.sh});
         check("readData1_1", readData1_1, e_l1.a);
         check("readData2_1", readData2_1, e_l1.b);
         check("extImm1", extImm1, e_l1.imm);
      end else if (e_z1) check("ctrl1_zero", ctrl1, 15'd0);
      if (e_v2) begin
         check("ctrl2", ctrl2, e_l2.c);
         check("l2_fields", {rs2, rt2, destReg2, shamt2}, {e_l2.rs, e_l2.rt, e_l2.dest, e_l2.sh});
         check("readData1_2", readData1_2, e_l2.a);
         check("readData2_2", readData2_2, e_l2.b);
         check("extImm2", extImm2, e_l2.imm);
      end else if (e_z2) check("ctrl2_zero", ctrl2, 15'd0);
   endtask

   task automatic step();
      #1;
      check("in_ready", in_ready, (m_held.size() == 0) && !stall);
      check("in_ready_ns", in_ready_ns, !stall);
      model_clock();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle();
      in_valid = 0; stall = 0; flush = 0;
      regWrite1_WB = 0; regWrite2_WB = 0; jal1_WB = 0; jal2_WB = 0;
   endtask

   task automatic pair(logic [31:0] a, logic [31:0] b);
      idle(); in_valid = 1; instruction1 = a; instruction2 = b;
   endtask

   task automatic do_reset();
      idle();
      #2 rst = 1'b1;
      #1;
      check("rst_valid", {out_valid1, out_valid2, out_valid1_ns, out_valid2_ns}, 4'd0);
      check("rst_ctrl", {ctrl1, ctrl2}, 30'd0);
      check("rst_fields", {rs1, rt1, destReg1, shamt1, rs2, rt2, destReg2, shamt2}, 40'd0);
      check("rst_data1", {readData1_1, readData2_1}, 64'd0);
      check("rst_data2", {readData1_2, readData2_2}, 64'd0);
      check("rst_imm", {extImm1, extImm2}, 64'd0);
      check("rst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_held.delete();
      e_v1 = 0; e_v2 = 0; e_z1 = 1; e_z2 = 1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      // $1=5, $2=7 via write-back
      idle();
      regWrite1_WB = 1; writeReg1_WB = 5'd1; writeData1_WB = 32'd5;
      regWrite2_WB = 1; writeReg2_WB = 5'd2; writeData2_WB = 32'd7;
      step();
      // Independent pair
      pair(enc(M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0), enc(M_SUB, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0));
      step();
      check("ind_v", {out_valid1, out_valid2}, 2'b11);
      check("ind_ops", {readData1_1, readData2_1}, {32'd5, 32'd7});
      check("ind_dest", {destReg1, destReg2}, {5'd3, 5'd6});
      check("ind_ready", in_ready, 1'b1);
      // RAW pair splits
      pair(enc(M_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'd4), enc(M_ADD, 5'd8, 5'd8, 5'd9, 5'd0, 16'd0));
      step();
      check("raw_c1_v2", out_valid2, 1'b0);
      check("raw_c1_ready", in_ready, 1'b0);
      idle();
      step();
      check("raw_c2_rs1", rs1, 5'd8);
      check("raw_c2_v", {out_valid1, out_valid2}, 2'b10);
      check("raw_c3_ready", in_ready, 1'b1);
      // lw pair: splits here, issues together without splitting
      pair(enc(M_LW, 5'd1, 5'd11, 5'd0, 5'd0, 16'd0), enc(M_LW, 5'd2, 5'd12, 5'd0, 5'd0, 16'd4));
      step();
      check("lw_split_v", {out_valid1, out_valid2}, 2'b10);
      check("lw_ns_v", {out_valid1_ns, out_valid2_ns}, 2'b11);
      check("lw_ns_dest2", destReg2_ns, 5'd12);
      idle();
      step();
      check("lw_hold_dest1", destReg1, 5'd12);
      // Same-cycle write-back to $10 on both ports
      pair(enc(M_ADD, 5'd10, 5'd0, 5'd13, 5'd0, 16'd0), 32'd0);
      regWrite1_WB = 1; writeReg1_WB = 5'd10; writeData1_WB = 32'h11;
      regWrite2_WB = 1; writeReg2_WB = 5'd10; writeData2_WB = 32'h22;
      step();
      check("byp_both", readData1_1, 32'h22);
      pair(enc(M_ADD, 5'd10, 5'd0, 5'd14, 5'd0, 16'd0), 32'd0);
      step();
      check("arr_r10", readData1_1, 32'h22);
      // jal write-back to $31, write to $0 ignored
      idle();
      regWrite1_WB = 1; jal1_WB = 1; writeReg1_WB = 5'd5; writeData1_WB = 32'h400;
      regWrite2_WB = 1; writeReg2_WB = 5'd0; writeData2_WB = 32'hdead;
      step();
      pair(enc(M_ADD, 5'd31, 5'd0, 5'd15, 5'd0, 16'd0), 32'd0);
      step();
      check("jal_r31", readData1_1, 32'h400);
      check("r0_zero", readData2_1, 32'd0);
      // HOLD, stall two cycles, then flush
      pair(enc(M_LW, 5'd1, 5'd11, 5'd0, 5'd0, 16'd0), enc(M_SW, 5'd2, 5'd12, 5'd0, 5'd0, 16'd8));
      step();
      idle(); stall = 1;
      step();
      step();
      check("stall_frozen", {out_valid1, out_valid2, destReg1}, {2'b10, 5'd11});
      flush = 1;
      step();
      check("flush_v", {out_valid1, out_valid2}, 2'b00);
      idle();
      step();
      check("flush_noissue", out_valid1, 1'b0);
      // Randomized traffic with a reset mid-run
      for (int i = 0; i < 1500; i++) begin
         idle();
         in_valid     = ($urandom_range(0, 99) < 80);
         stall        = ($urandom_range(0, 99) < 15);
         flush        = ($urandom_range(0, 99) < 4);
         instruction1 = enc(mn_t'($urandom_range(0, 21)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom), 16'($urandom));
         instruction2 = enc(mn_t'($urandom_range(0, 21)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom), 16'($urandom));
         regWrite1_WB = $urandom_range(0, 1); jal1_WB = ($urandom_range(0, 9) == 0);
         regWrite2_WB = $urandom_range(0, 1); jal2_WB = ($urandom_range(0, 9) == 0);
         writeReg1_WB = 5'($urandom_range(0, 9)); writeData1_WB = $urandom;
         writeReg2_WB = 5'($urandom_range(0, 9)); writeData2_WB = $urandom;
         step();
         if (i == 750) do_reset();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised two-lane decode and issue stage for the dual-issue MIPS pipeline, replacing the purely combinational decoder with a registered ID/EX boundary. It decodes an instruction pair through two `controlUnit` instances and reads operands from a 4-read/2-write register file with write-back bypass. It detects intra-bundle conflicts and splits a conflicting pair into two consecutive single-lane issues. The stage supports stall and flush from the hazard unit.

## Interface
Parameters:
- `DATA_W`, 32, register, operand and extended-immediate width. The immediate is sign-extended from 16 bits to `DATA_W`.
- `SPLIT_EN`, 1. When 1, conflicting pairs are split. When 0, pairs always issue together and `in_ready` depends only on `stall`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the instruction pair is valid this cycle.
- `in_ready`  out  1  the stage accepts the pair this cycle.
- `instruction1`, `instruction2`  in  32  fetched pair; lane 1 is older.
- `stall`  in  1  hold all output registers and state.
- `flush`  in  1  discard outputs and any held instruction.
- `regWrite1_WB`, `regWrite2_WB`  in  1  write-back enables.
- `jal1_WB`, `jal2_WB`  in  1  force the write address to 31.
- `writeReg1_WB`, `writeReg2_WB`  in  5  write-back addresses.
- `writeData1_WB`, `writeData2_WB`  in  `DATA_W`  independent write-back data, one per port.
- `out_valid1`, `out_valid2`  out  1  the registered lane is valid.
- `ctrl1`, `ctrl2`  out  15  registered control vector {RegDst, Branch, MemReadEn, MemtoReg, MemWriteEn, RegWriteEn, ALUSrc, jr, jal, bne, jump, AluOp[3:0]}.
- `rs1`, `rt1`, `destReg1`, `shamt1`, `rs2`, `rt2`, `destReg2`, `shamt2`  out  5  registered fields. `destReg` is `rd` when RegDst=1, otherwise `rt`.
- `readData1_1`, `readData2_1`, `readData1_2`, `readData2_2`, `extImm1`, `extImm2`  out  `DATA_W`  registered operands and immediates.

## Operation
- The stage has two states, PAIR and HOLD. Reset enters PAIR.
- `in_ready = (state==PAIR) & ~stall`. A pair is accepted when `in_valid & in_ready`.
- A conflict exists, for `SPLIT_EN=1`, when any of the following holds:
  - Lane 1 has RegWriteEn, its dest is nonzero, and its dest equals `rs2` or `rt2`. The lane-1 dest is 31 when lane 1 is jal.
  - Both lanes have RegWriteEn and their dest fields are equal.
  - Both lanes have MemReadEn or MemWriteEn set.
  - Lane 1 is Branch, bne, jump, jr or jal.
- PAIR, pair accepted, no conflict: both lanes are registered. `out_valid1` and `out_valid2` = `in_valid`.
- PAIR, pair accepted, conflict:
  - Only lane 1 is registered; `out_valid2`=0.
  - `instruction2` is latched into the hold buffer and the state moves to HOLD.
- HOLD, no stall:
  - The held instruction is decoded and registered in lane 1; `out_valid2`=0.
  - The state returns to PAIR.
  - The fetch inputs are ignored because `in_ready`=0.
- PAIR with `in_valid`=0 and no stall: `out_valid1` and `out_valid2` are cleared to 0.
- Stall: all outputs, the state and the hold buffer keep their values.
- Flush:
  - `out_valid1`, `out_valid2` and `ctrl` are cleared to 0, the hold buffer is discarded and the state moves to PAIR.
  - Flush has priority over stall and over acceptance.
- Register file:
  - 32 entries of `DATA_W` bits; entry 0 always reads 0.
  - The write address is 31 when `jal*_WB` is set, otherwise `writeReg*_WB`.
  - Writes occur on the rising edge, and reads are combinational.
- Bypass: a read address that matches an active write address with a nonzero address returns that port's write data in the same cycle. If both ports write the same address, port 2 wins for the stored value and for the bypass.

## Timing
- Latency: one cycle from acceptance, or from the HOLD cycle, to the registered outputs.
- Throughput: one pair per cycle without conflicts; a conflicting pair takes two cycles.
- Reset, asynchronous: all outputs are 0, the state is PAIR, the hold buffer is 0 and all register-file entries are 0. `in_ready` follows its equation after reset, so it is 1 when `stall`=0.
- A write-back in cycle N is visible to a decode in cycle N through the bypass, and from the array in cycle N+1.
- Reset mid-HOLD discards the held instruction; the state is PAIR once `rst` deasserts.

## Test plan
- Independent pair (`add $3,$1,$2` / `sub $6,$4,$5`) with $1=5, $2=7 written beforehand:
  - Next cycle `out_valid1`=`out_valid2`=1, `readData1_1`=5, `readData2_1`=7, `destReg1`=3, `destReg2`=6.
  - `in_ready` stays 1.
- RAW pair (`addi $8,$0,4` / `add $9,$8,$8`):
  - Cycle 1: lane 1 only, `in_ready`=0.
  - Cycle 2: the `add` appears in lane 1 with `rs1`=8, `out_valid2`=0.
  - Cycle 3: `in_ready`=1.
- Two `lw` instructions in one pair: the pair splits into two single-lane issues.
- With `SPLIT_EN`=0, the same `lw` pair issues together.
- Same-cycle write-back to $10 on both ports (port 1 = 0x11, port 2 = 0x22) while decoding `rs1`=10: `readData1_1`=0x22, and $10 holds 0x22 afterwards.
- Write-back with `jal1_WB`=1 and data 0x400: $31 = 0x400. A write to $0 reads back as 0.
- In HOLD, assert stall for 2 cycles, then flush:
  - Outputs are frozen during the stall.
  - After the flush, `out_valid*`=0, the state is PAIR and the held instruction is never issued.
- Assert `rst` mid-operation: all outputs read 0 immediately.
